demux_1_n_stream: RTL and testbench
===================================

# demux_1_n_stream

Index-driven stream demultiplexer: routes each accepted input beat to one of `N` output lanes selected by `in_sel`. It is the distribution-side counterpart of the array-indexed 4:1 mux: one producer fans out to `N` consumers. Each lane has its own 2-entry buffer, so a stalled lane never blocks traffic addressed to other lanes. It sits between a single producer and `N` independent valid/ready consumers.

## Interface
- `W`, default 4: data width per beat.
- `N`, default 4: number of output lanes, ≥ 2.
- `SW`, default `$clog2(N)`: width of `in_sel`.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in_valid`  input  1: producer has a beat.
- `in_ready`  output  1: beat is accepted this cycle when `in_valid && in_ready`.
- `in_data`  input  W: beat payload.
- `in_sel`  input  SW: destination lane index; qualified by `in_valid`.
- `out_valid`  output  N: bit `i` means lane `i` head is valid.
- `out_ready`  input  N: bit `i` means lane `i` consumer accepts its head.
- `out_data`  output  N*W: lane `i` head occupies bits `[i*W +: W]`.
- `busy`  output  1: at least one lane buffer is non-empty.

## Operation
- **Per-lane buffer.**
  - Each lane `i` is a 2-entry FIFO with occupancy `cnt[i]` ∈ {0,1,2}.
  - Read/write pointers are 1 bit wide and wrap from 1 to 0.
- **Input acceptance.**
  - `in_ready = (in_sel < N) && (cnt[in_sel] != 2)`.
  - This is combinational from `in_sel` and registered state only. It never depends on `out_ready`, so there is no in→out ready path.
- **Illegal select.** If `in_sel ≥ N` (possible only when `N` is not a power of 2), `in_ready = 0` and the beat stalls forever. Generating a legal select is the producer's responsibility.
- **Push.** `in_valid && in_ready`: write `in_data` at `wptr[in_sel]`, advance `wptr[in_sel]`.
- **Pop.** `out_valid[i] && out_ready[i]`: advance `rptr[i]`.
- **Occupancy update per lane.** `cnt` += push, −= pop.
  - Simultaneous push and pop on the same lane keeps `cnt` unchanged. Allowed when `cnt` is 1. When `cnt` is 2, push is blocked even though a pop occurs that cycle.
  - Pops on any subset of lanes can occur in the same cycle as a push to another lane.
- **Lane outputs.**
  - `out_valid[i] = (cnt[i] != 0)`.
  - `out_data` lane `i` = `mem[i][rptr[i]]`.
  - When `cnt[i] == 0`, the lane's `out_data` value is the last stored entry and is don't-care.
- **`busy`** = OR over all `out_valid`.
- **Ordering.**
  - Beats addressed to the same lane exit in acceptance order.
  - There is no ordering guarantee across lanes.
- **Reset.** Asynchronous assertion while `rst_n = 0`:
  - all `cnt`, `wptr`, `rptr` = 0;
  - all storage = 0, so `out_valid = 0`, `out_data = 0`, `busy = 0`;
  - `in_ready` = 1 for any legal `in_sel`.
  - Reset mid-transfer discards all buffered beats; no partial state survives.
- **Deassertion.** Reset deassertion is synchronised externally. The first accepted beat is possible on the first rising edge after deassertion.

## Timing
- **Latency.** A beat accepted at edge `t` is visible on `out_valid`/`out_data` after edge `t`, i.e. in cycle `t+1`. Latency is 1 cycle; there is no combinational in→out data path.
- **Throughput.**
  - One beat per cycle into any lane whose consumer keeps `out_ready = 1`.
  - A lane absorbs 2 beats while stalled; the third stalls the producer.
- **Hold rule.** `out_valid[i]` and the lane's `out_data` stay stable while `out_valid[i] && !out_ready[i]`.
- **Ready recovery.** After a pop on a full lane at edge `t`, `in_ready` for that lane is 1 in cycle `t+1`.

## Test plan
- **Reset.** Drive `rst_n = 0` mid-cycle with lanes holding data → outputs clear immediately: `out_valid = 4'b0000`, `busy = 0`, `out_data = 0`. After release, `in_ready = 1` for `sel` 0..3.
- **Routing.** With all `out_ready = 1`, send `sel/data` pairs (0,4'h1), (1,4'h2), (2,4'h3), (3,4'h4), one per cycle → each appears only on its lane one cycle after acceptance; other lanes' `out_valid` stay 0.
- **Back-pressure.** Set `out_ready[2] = 0` and send 3 beats 4'hA, 4'hB, 4'hC to lane 2:
  - after 2 beats, `in_ready = 0` for `sel = 2`;
  - a beat to lane 0 is still accepted;
  - releasing `out_ready[2]` yields A then B, then C is accepted, in order.
- **Full lane, simultaneous pop.** With lane 1 at `cnt = 2`, pulse `out_ready[1]` in the same cycle `in_valid` targets lane 1 → push is refused that cycle and accepted the next cycle; the lane then holds the old second beat followed by the new beat.
- **Single-entry streaming.** With lane 3 at `cnt = 1` and continuous push plus pop for 8 cycles using data 0..7 → `cnt` stays 1, the output sequence is the prior head then 0..6, and there are no drops or duplicates.
- **Random stress.** Run 10k cycles with random `in_valid`/`in_sel`/`out_ready` against a per-lane queue model → per-lane ordering is exact, no drops or duplicates, and the stability rule holds.

Source files
------------

// File: rtl/demux_1_n_stream.sv
// Index-driven 1:N stream demultiplexer with a 2-entry FIFO per output lane.
// A stalled lane only back-pressures beats addressed to that lane.
module demux_1_n_stream #(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic           busy
);

    logic [1:0]   cnt_q [N];
    logic [1:0]   cnt_d [N];
    logic [N-1:0] wptr_q, wptr_d;
    logic [N-1:0] rptr_q, rptr_d;
    logic [W-1:0] mem_q [N][2];
    logic [W-1:0] mem_d [N][2];
    logic [N-1:0] lane_hit;
    logic [N-1:0] push;
    logic [N-1:0] pop;

    // An out-of-range select matches no lane, so in_ready stays low for it.
    always_comb begin
        in_ready = 1'b0;
        out_data = '0;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        mem_d    = mem_q;
        lane_hit = '0;
        push     = '0;
        pop      = '0;
        for (int i = 0; i < N; i++) begin
            lane_hit[i] = (in_sel == SW'(i));
            if (lane_hit[i] && (cnt_q[i] != 2'd2)) begin
                in_ready = 1'b1;
            end
            push[i] = in_valid && lane_hit[i] && (cnt_q[i] != 2'd2);
            pop[i]  = (cnt_q[i] != 2'd0) && out_ready[i];
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                default: cnt_d[i] = cnt_q[i];
            endcase
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = in_data;
                wptr_d[i]           = ~wptr_q[i];
            end
            if (pop[i]) begin
                rptr_d[i] = ~rptr_q[i];
            end
            out_data[i*W +: W] = mem_q[i][rptr_q[i]];
        end
    end

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < N; i++) begin
            out_valid[i] = (cnt_q[i] != 2'd0);
        end
    end

    assign busy = |out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]    <= 2'd0;
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Self-checking bench for demux_1_n_stream: vector table, corner sequences,
// and random traffic checked against per-lane reference queues.
module tb_demux_1_n_stream;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
    logic           busy;

    int n_total;
    int n_pass;

    logic [W-1:0] mq [N][$];

    typedef struct {
        logic          v;
        logic [SW-1:0] sel;
        logic [W-1:0]  d;
        logic [N-1:0]  ordy;
        logic          exp_ready;
        logic [N-1:0]  exp_ov;
    } vec_t;

    vec_t tbl [14];

    demux_1_n_stream #(.W(W), .N(N), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the queue model, then advance one clock and update the model.
    task automatic step();
        logic [N-1:0] exp_ov;
        logic [N-1:0] pops;
        logic         exp_rdy;
        logic         acc;
        #1;
        exp_rdy = (mq[in_sel].size() != 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int i = 0; i < N; i++) begin
            exp_ov[i] = (mq[i].size() != 0);
            pops[i]   = exp_ov[i] && out_ready[i];
        end
        chk("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
        chk("busy", {31'd0, busy}, {31'd0, |exp_ov});
        for (int i = 0; i < N; i++) begin
            if (exp_ov[i]) begin
                chk($sformatf("lane%0d_data", i), {28'd0, out_data[i*W +: W]}, {28'd0, mq[i][0]});
            end
        end
        acc = in_valid && exp_rdy;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (pops[i]) void'(mq[i].pop_front());
        end
        if (acc) mq[in_sel].push_back(in_data);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'h0);

        tbl[0]  = '{1'b1, 2'd0, 4'h1, 4'hF, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 2'd1, 4'h2, 4'hF, 1'b1, 4'b0001};
        tbl[2]  = '{1'b1, 2'd2, 4'h3, 4'hF, 1'b1, 4'b0010};
        tbl[3]  = '{1'b1, 2'd3, 4'h4, 4'hF, 1'b1, 4'b0100};
        tbl[4]  = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b1000};
        tbl[5]  = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 2'd2, 4'hA, 4'hB, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 2'd2, 4'hB, 4'hB, 1'b1, 4'b0100};
        tbl[8]  = '{1'b1, 2'd2, 4'hC, 4'hB, 1'b0, 4'b0100};
        tbl[9]  = '{1'b1, 2'd0, 4'h5, 4'hB, 1'b1, 4'b0100};
        tbl[10] = '{1'b1, 2'd2, 4'hC, 4'hF, 1'b0, 4'b0101};
        tbl[11] = '{1'b1, 2'd2, 4'hC, 4'hF, 1'b1, 4'b0100};
        tbl[12] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0100};
        tbl[13] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000};

        #12;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < N; s++) begin
            in_sel = SW'(s);
            #1;
            chk($sformatf("rst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);

        // Routing and back-pressure vectors
        for (int k = 0; k < 14; k++) begin
            drive(tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].ordy);
            #1;
            chk($sformatf("tbl%0d_ready", k), {31'd0, in_ready}, {31'd0, tbl[k].exp_ready});
            chk($sformatf("tbl%0d_valid", k), {28'd0, out_valid}, {28'd0, tbl[k].exp_ov});
            step();
        end

        // Full lane 1 with simultaneous pop: push refused, accepted next cycle
        drive(1'b1, 2'd1, 4'h6, 4'h0); step();
        drive(1'b1, 2'd1, 4'h7, 4'h0); step();
        drive(1'b1, 2'd1, 4'h8, 4'b0010);
        #1 chk("full_pop_refused", {31'd0, in_ready}, 32'd0);
        step();
        drive(1'b1, 2'd1, 4'h8, 4'h0);
        #1 chk("full_pop_recover", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, 2'd1, 4'h0, 4'h0);
        #1 chk("full_pop_head", {28'd0, out_data[1*W +: W]}, 32'h7);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        for (int k = 0; k < 3; k++) step();

        // Single-entry streaming on lane 3
        drive(1'b1, 2'd3, 4'h9, 4'h0); step();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'd3, W'(k), 4'b1000);
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        #1 chk("stream_tail", {28'd0, out_data[3*W +: W]}, 32'h7);
        for (int k = 0; k < 2; k++) step();

        // Mid-cycle reset with buffered data
        drive(1'b1, 2'd0, 4'hD, 4'h0); step();
        drive(1'b1, 2'd2, 4'hE, 4'h0); step();
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out_data", {16'd0, out_data}, 32'd0);
        for (int i = 0; i < N; i++) mq[i].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < N; s++) begin
            in_sel = SW'(s);
            #1;
            chk($sformatf("midrst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);

        // Random stress
        for (int k = 0; k < 10000; k++) begin
            drive(1'($urandom_range(0, 1)), SW'($urandom_range(0, N - 1)),
                  W'($urandom), N'($urandom));
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        for (int k = 0; k < 4; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
